exce_handler_seq: RTL and testbench
===================================

// Module: exce_handler_seq
// PURPOSE
//  Exception sequencer for the multicycle CPU; drives the far end of mux_ExceCtrl.
//  Detects invalid-opcode, overflow and divide-by-zero flags and saves EPC.
//  Drives the 2-bit select to the exception-address mux, whose output addresses
//  memory at 253/254/255. Reads the handler byte, zero-extends it and loads it into PC.
//  Stalls the main control unit (busy) while the sequence runs.
// PARAMETERS
//  MEM_LAT     1  cycles from mem_rd assertion to mem_byte valid (1..7)
//  EPC_OFFSET  4  subtracted from pc_in to form EPC (pc_in is already PC+4)
// PORTS
//  clk            in   1   system clock, rising edge
//  reset_n        in   1   synchronous, active-low reset
//  exc_opcode     in   1   invalid opcode flag (level, sampled in IDLE)
//  exc_overflow   in   1   ALU overflow flag (level, sampled in IDLE)
//  exc_div0       in   1   divide-by-zero flag (level, sampled in IDLE)
//  pc_in          in   32  current PC (faulting instr + 4)
//  mem_byte       in   8   byte returned by memory at mux-selected address
//  escolha        out  2   select to mux_ExceCtrl: 00=253 01=254 10=255 11=reserved
//  mem_rd         out  1   memory read request
//  epc_out        out  32  EPC value
//  epc_we         out  1   EPC register write enable
//  pc_novo        out  32  handler address {24'b0, mem_byte}
//  pc_we          out  1   PC write enable
//  exc_cause      out  2   latched cause, same encoding as escolha
//  busy           out  1   stall request to main control
// BEHAVIOUR
//  - All outputs registered (Moore). Reset (reset_n=0 at edge) -> IDLE, every output 0.
//    Applies from any state, including mid-sequence; no partial EPC/PC write follows.
//  - States: IDLE -> SAVE -> READ -> LOAD -> IDLE.
//  - IDLE: no flag is set -> stay. Any flag is set at edge k -> go to SAVE.
//    On that edge: latch cause by priority (opcode > overflow > div0).
//    Also on that edge: latch epc_out = pc_in - EPC_OFFSET, 32-bit modulo wrap.
//  - SAVE (cycle k+1): epc_we=1, busy=1, escolha=cause. Then go to READ.
//  - READ (cycles k+2 .. k+1+MEM_LAT): mem_rd=1, busy=1, escolha=cause.
//    A 3-bit down-counter is loaded with MEM_LAT. mem_byte is captured on the last READ edge.
//  - LOAD (cycle k+2+MEM_LAT): pc_we=1 for exactly one cycle, busy=1.
//    pc_novo = {24'h0, captured byte}; zero-extend, never sign-extend. Then go to IDLE.
//  - escolha and exc_cause hold constant from SAVE through LOAD; escolha=00 in IDLE.
//  - exc_cause holds its value in IDLE until the next exception (debug visibility).
//  - epc_out and pc_novo hold their last value in IDLE.
//  - Flags asserted while not IDLE are ignored; they are not queued.
//  - Back-to-back: a flag asserted in the first IDLE cycle after LOAD is accepted.
//  - Total busy cycles = 2 + MEM_LAT.
// TESTING
//  1. MEM_LAT=1: exc_overflow=1, pc_in=0x40, mem_byte=0x7A.
//     -> epc_we at k+1 with epc_out=0x3C; escolha=01 during k+1..k+3; mem_rd at k+2;
//     -> pc_we at k+3 with pc_novo=0x0000007A; busy low at k+4.
//  2. exc_opcode=1 and exc_div0=1 in the same cycle -> exc_cause=00, escolha=00, one sequence.
//  3. exc_div0 pulse during READ of an overflow sequence -> ignored.
//     Fresh exc_div0 after return -> escolha=10, second EPC write.
//  4. reset_n=0 during READ -> next cycle all outputs 0, state IDLE; no pc_we ever seen.
//  5. MEM_LAT=3, pc_in=0x0 -> epc_out=0xFFFFFFFC; mem_rd for 3 cycles; pc_we at k+5.
//  6. mem_byte=0xFF -> pc_novo=0x000000FF (zero-extended).

Source files
------------

// File: rtl/exce_handler_seq.sv
// Exception sequencer: latches cause and EPC, then reads the handler byte
// from the exception vector area and loads it into PC while stalling the main control.
module exce_handler_seq #(
    parameter int unsigned MEM_LAT    = 1,
    parameter logic [31:0] EPC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_byte,
    output logic [1:0]  escolha,
    output logic        mem_rd,
    output logic [31:0] epc_out,
    output logic        epc_we,
    output logic [31:0] pc_novo,
    output logic        pc_we,
    output logic [1:0]  exc_cause,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SAVE = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;
    localparam logic [1:0] S_LOAD = 2'd3;

    localparam logic [2:0] LAT3 = 3'(MEM_LAT);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  escolha_q, escolha_d;
    logic        mem_rd_q, mem_rd_d;
    logic [31:0] epc_q, epc_d;
    logic        epc_we_q, epc_we_d;
    logic [31:0] pc_novo_q, pc_novo_d;
    logic        pc_we_q, pc_we_d;
    logic [1:0]  cause_q, cause_d;
    logic        busy_q, busy_d;

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        pc_novo_d = pc_novo_q;
        escolha_d = 2'b00;
        mem_rd_d  = 1'b0;
        epc_we_d  = 1'b0;
        pc_we_d   = 1'b0;
        busy_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exc_opcode || exc_overflow || exc_div0) begin
                    state_d = S_SAVE;
                    if (exc_opcode)
                        cause_d = 2'b00;
                    else if (exc_overflow)
                        cause_d = 2'b01;
                    else
                        cause_d = 2'b10;
                    epc_d     = pc_in - EPC_OFFSET;
                    epc_we_d  = 1'b1;
                    busy_d    = 1'b1;
                    escolha_d = cause_d;
                end
            end
            S_SAVE: begin
                state_d   = S_READ;
                cnt_d     = LAT3;
                mem_rd_d  = 1'b1;
                busy_d    = 1'b1;
                escolha_d = cause_q;
            end
            S_READ: begin
                busy_d    = 1'b1;
                escolha_d = cause_q;
                if (cnt_q == 3'd1) begin
                    state_d   = S_LOAD;
                    pc_novo_d = {24'h0, mem_byte};
                    pc_we_d   = 1'b1;
                end else begin
                    cnt_d    = cnt_q - 3'd1;
                    mem_rd_d = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cause_q   <= '0;
            epc_q     <= '0;
            pc_novo_q <= '0;
            escolha_q <= '0;
            mem_rd_q  <= 1'b0;
            epc_we_q  <= 1'b0;
            pc_we_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            pc_novo_q <= pc_novo_d;
            escolha_q <= escolha_d;
            mem_rd_q  <= mem_rd_d;
            epc_we_q  <= epc_we_d;
            pc_we_q   <= pc_we_d;
            busy_q    <= busy_d;
        end
    end

    assign escolha   = escolha_q;
    assign mem_rd    = mem_rd_q;
    assign epc_out   = epc_q;
    assign epc_we    = epc_we_q;
    assign pc_novo   = pc_novo_q;
    assign pc_we     = pc_we_q;
    assign exc_cause = cause_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_exce_handler_seq.sv
// Bench for exce_handler_seq: two instances (MEM_LAT 1 and 3) share stimulus;
// a timestamped transaction model predicts every output cycle by cycle.
module tb_exce_handler_seq;

    typedef struct {
        int          t_epc;
        int          t_pc;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic [7:0]  hbyte;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        f_opc, f_ovf, f_div;
    logic [31:0] pc_in;
    logic [7:0]  mem_tab [4];
    logic [7:0]  junk;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(negedge clk) junk <= 8'($urandom);

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lat_inst%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : 3;

        logic [1:0]  escolha, exc_cause;
        logic        mem_rd, epc_we, pc_we, busy;
        logic [31:0] epc_out, pc_novo;
        logic [7:0]  mem_byte;
        int          rd_cnt = 0;
        int          cyc = 0;
        int          free_cyc = 0;
        exp_t        q[$];
        logic [31:0] last_epc = '0;
        logic [31:0] last_pc = '0;
        logic [1:0]  last_cause = '0;

        exce_handler_seq #(.MEM_LAT(L), .EPC_OFFSET(32'd4)) u_dut (
            .clk(clk), .reset_n(reset_n),
            .exc_opcode(f_opc), .exc_overflow(f_ovf), .exc_div0(f_div),
            .pc_in(pc_in), .mem_byte(mem_byte),
            .escolha(escolha), .mem_rd(mem_rd), .epc_out(epc_out), .epc_we(epc_we),
            .pc_novo(pc_novo), .pc_we(pc_we), .exc_cause(exc_cause), .busy(busy)
        );

        // Memory returns the vector byte only after mem_rd has been held for L cycles.
        assign mem_byte = (mem_rd && rd_cnt == int'(L) - 1) ? mem_tab[escolha] : junk;

        always @(posedge clk) rd_cnt <= mem_rd ? rd_cnt + 1 : 0;

        always @(posedge clk) begin : model
            exp_t e;
            if (!reset_n) begin
                q.delete();
                free_cyc   <= 0;
                last_epc   <= '0;
                last_pc    <= '0;
                last_cause <= '0;
            end else begin
                if (q.size() != 0 && q[0].t_pc == cyc) begin
                    last_epc   <= q[0].epc;
                    last_pc    <= {24'h0, q[0].hbyte};
                    last_cause <= q[0].cause;
                    void'(q.pop_front());
                end
                if (cyc >= free_cyc && (f_opc || f_ovf || f_div)) begin
                    e.cause = f_opc ? 2'd0 : (f_ovf ? 2'd1 : 2'd2);
                    e.epc   = pc_in - 32'd4;
                    e.hbyte = mem_tab[e.cause];
                    e.t_epc = cyc + 1;
                    e.t_pc  = cyc + 2 + int'(L);
                    q.push_back(e);
                    free_cyc <= cyc + 3 + int'(L);
                end
            end
            cyc <= cyc + 1;
        end

        always @(negedge clk) begin : monitor
            exp_t        e;
            logic [5:0]  es;
            logic [1:0]  ecause;
            logic [31:0] eepc, epcnv;
            if (q.size() != 0) begin
                e      = q[0];
                es     = {1'b1, cyc == e.t_epc, (cyc > e.t_epc) && (cyc < e.t_pc), cyc == e.t_pc, e.cause};
                ecause = e.cause;
                eepc   = e.epc;
                epcnv  = (cyc == e.t_pc) ? {24'h0, e.hbyte} : last_pc;
            end else begin
                es     = 6'b0;
                ecause = last_cause;
                eepc   = last_epc;
                epcnv  = last_pc;
            end
            chk("busy_epcwe_memrd_pcwe_escolha", g, {26'b0, busy, epc_we, mem_rd, pc_we, escolha}, {26'b0, es});
            chk("exc_cause", g, {30'b0, exc_cause}, {30'b0, ecause});
            chk("epc_out", g, epc_out, eepc);
            chk("pc_novo", g, pc_novo, epcnv);
        end
    end

    task automatic fire(input logic [2:0] f, input logic [31:0] pc);
        @(negedge clk);
        {f_opc, f_ovf, f_div} = f;
        pc_in = pc;
        @(negedge clk);
        {f_opc, f_ovf, f_div} = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        {f_opc, f_ovf, f_div} = 3'b000;
        pc_in = '0;
        mem_tab[0] = 8'h11; mem_tab[1] = 8'h7A; mem_tab[2] = 8'h33; mem_tab[3] = 8'h44;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        // Overflow with pc_in 0x40: EPC 0x3C, handler 0x7A.
        fire(3'b010, 32'h40);
        idle(8);
        // Opcode and div0 together: opcode wins.
        fire(3'b101, 32'h100);
        idle(8);
        // div0 pulse lands in READ and is dropped; a fresh one is taken later.
        fire(3'b010, 32'h200);
        fire(3'b001, 32'h204);
        idle(8);
        fire(3'b001, 32'h208);
        idle(8);
        // Reset during READ aborts the sequence.
        fire(3'b010, 32'h300);
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        idle(8);
        // EPC wrap and zero extension of a 0xFF handler byte.
        mem_tab[2] = 8'hFF;
        fire(3'b001, 32'h0);
        idle(8);
        // Flag held high: sequences follow back to back.
        @(negedge clk);
        f_ovf = 1'b1; pc_in = 32'h1000;
        idle(14);
        f_ovf = 1'b0;
        idle(8);
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++) mem_tab[i] = 8'($urandom);
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                {f_opc, f_ovf, f_div} = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                pc_in   = $urandom;
                reset_n = ($urandom_range(0, 49) != 0);
            end
            @(negedge clk);
            {f_opc, f_ovf, f_div} = 3'b000;
            reset_n = 1'b1;
            idle(8);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
